// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between the I-cache
// miss port (read only) and the D-cache miss port (read/write).
// Round-robin grant, registered command/data, one-cycle ready pulse back to
// the granted side, and a watchdog that aborts a stalled transaction.
//
// Request/ready protocol: a requester raises its request (i_read, or
// d_read/d_write) and holds it with stable operands until its ready pulses
// for exactly one cycle; it must drop the request in the cycle after ready.
// Toward memory, mem_read/mem_write stay high with stable operands until
// mem_ready pulses (or the watchdog expires). Only one transaction is ever
// outstanding.
module mem_port_arbiter #(
   parameter int ADDR_W  = 28,
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 1023,
   parameter int CNT_W   = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              grant_d,
   output logic              timeout_err,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                i_ready_q, i_ready_d;
   logic                d_ready_q, d_ready_d;
   logic                grant_d_q, grant_d_d;
   logic                timeout_err_q, timeout_err_d;
   logic                last_grant_q, last_grant_d;   // 1 = D side was granted last
   logic [CNT_W-1:0]    wd_q, wd_d;

   logic                i_req, d_req, pick_d;
   logic [CNT_W-1:0]    wd_inc;

   assign i_req  = i_read;
   assign d_req  = d_read | d_write;
   // D wins when it is alone, or when both contend and I had the last grant.
   assign pick_d = d_req & (~i_req | ~last_grant_q);
   assign wd_inc = wd_q + 1'b1;

   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign i_ready     = i_ready_q;
   assign d_ready     = d_ready_q;
   assign grant_d     = grant_d_q;
   assign timeout_err = timeout_err_q;
   assign dbg_state   = state_q;

   // State and output registers; reset drops every command and pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         i_rdata_q     <= '0;
         d_rdata_q     <= '0;
         i_ready_q     <= 1'b0;
         d_ready_q     <= 1'b0;
         grant_d_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         last_grant_q  <= 1'b1;
         wd_q          <= '0;
      end else begin
         state_q       <= state_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         i_rdata_q     <= i_rdata_d;
         d_rdata_q     <= d_rdata_d;
         i_ready_q     <= i_ready_d;
         d_ready_q     <= d_ready_d;
         grant_d_q     <= grant_d_d;
         timeout_err_q <= timeout_err_d;
         last_grant_q  <= last_grant_d;
         wd_q          <= wd_d;
      end
   end

   // Next-state: arbitrate in IDLE, wait for memory or watchdog in ISSUE,
   // pulse ready in RESP.
   always_comb begin
      state_d       = state_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      i_rdata_d     = i_rdata_q;
      d_rdata_d     = d_rdata_q;
      i_ready_d     = 1'b0;
      d_ready_d     = 1'b0;
      grant_d_d     = grant_d_q;
      timeout_err_d = timeout_err_q;
      last_grant_d  = last_grant_q;
      wd_d          = wd_q;

      unique case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               grant_d_d    = pick_d;
               last_grant_d = pick_d;
               wd_d         = '0;
               state_d      = ISSUE;
               if (pick_d) begin
                  // A simultaneous read+write request is serviced as a write.
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  mem_write_d = d_write;
                  mem_read_d  = ~d_write;
               end else begin
                  mem_addr_d  = i_addr;
                  mem_read_d  = 1'b1;
                  mem_write_d = 1'b0;
               end
            end
         end
         ISSUE: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (mem_read_q) begin
                  if (grant_d_q) d_rdata_d = mem_rdata;
                  else           i_rdata_d = mem_rdata;
               end
               i_ready_d = ~grant_d_q;
               d_ready_d = grant_d_q;
               state_d   = RESP;
            end else if (wd_inc == CNT_W'(TIMEOUT)) begin
               // Memory never answered: abort, keep old rdata, still release the requester.
               mem_read_d    = 1'b0;
               mem_write_d   = 1'b0;
               timeout_err_d = 1'b1;
               i_ready_d     = ~grant_d_q;
               d_ready_d     = grant_d_q;
               wd_d          = wd_inc;
               state_d       = RESP;
            end else begin
               wd_d = wd_inc;
            end
         end
         RESP: begin
            wd_d    = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected commands and responses are
// queued by the stimulus thread, a monitor pops and compares them whenever
// the DUT presents a command or a ready pulse.
module tb_mem_port_arbiter;
   localparam int ADDR_W  = 28;
   localparam int DATA_W  = 128;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;
   localparam int RW      = 3 + 2 * DATA_W;       // {is_timeout, timeout_err, side, i_rdata, d_rdata}
   localparam int CW      = 3 + ADDR_W + DATA_W;  // {grant_d, read, write, addr, wdata}
   localparam int CHK_W   = 260;

   logic              clk;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              grant_d;
   logic              timeout_err;
   logic [1:0]        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [RW-1:0] exp_q[$];
   logic [CW-1:0] cmd_q[$];

   // memory model controls
   bit mem_en    = 1'b1;
   int mem_lat   = 5;
   int late_req  = 0;
   int late_done = 0;
   int pulse_cyc = -10;

   logic [DATA_W-1:0] exp_i, exp_d;
   localparam logic [DATA_W-1:0] WB_LINE  = {8{16'h1234}};
   localparam logic [DATA_W-1:0] WB_LINE2 = {4{32'h5A5A_0F0F}};
   localparam logic [DATA_W-1:0] A5_LINE  = {16{8'hA5}};

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant_d(grant_d), .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   // clock and cycle counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, expected finish within time budget");
      $fatal(1, "bench stopped");
   end

   task automatic check(input string name, input logic [CHK_W-1:0] act, input logic [CHK_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory contents as a function of line address
   function automatic logic [DATA_W-1:0] line_for(input logic [ADDR_W-1:0] a);
      if (a == 28'h0000040) return A5_LINE;
      return {4{4'hC, a}};
   endfunction

   // memory responder: answers a command mem_lat cycles later, or fires a
   // stray mem_ready pulse when late_req is bumped
   initial begin
      bit pend;
      int cnt;
      pend      = 1'b0;
      cnt       = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         if (mem_ready) begin
            mem_ready = 1'b0;
            pend      = 1'b0;
         end else if (late_req != late_done) begin
            late_done++;
            mem_ready = 1'b1;
            mem_rdata = {4{32'hDEAD_BEEF}};
         end else if (rst) begin
            pend = 1'b0;
         end else if (mem_en && (mem_read || mem_write)) begin
            if (!pend) begin
               pend = 1'b1;
               cnt  = mem_lat - 1;
            end else if (cnt == 0) begin
               mem_ready = 1'b1;
               mem_rdata = line_for(mem_addr);
               pulse_cyc = cyc;
            end else begin
               cnt--;
            end
         end
      end
   end

   // monitor / scoreboard
   initial begin
      logic [RW-1:0] e;
      logic [CW-1:0] cur, now;
      bit active;
      active = 1'b0;
      cur    = '0;
      forever begin
         @(negedge clk);
         check("cmd_exclusive", CHK_W'(mem_read & mem_write), '0);
         check("ready_exclusive", CHK_W'(i_ready & d_ready), '0);
         now = {grant_d, mem_read, mem_write, mem_addr, (mem_write ? mem_wdata : {DATA_W{1'b0}})};
         if (mem_read || mem_write) begin
            if (!active) begin
               active = 1'b1;
               if (cmd_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_cmd: got %h expected no command", now);
                  cur = now;
               end else begin
                  cur = cmd_q.pop_front();
                  check("cmd", CHK_W'(now), CHK_W'(cur));
               end
            end else begin
               check("cmd_stable", CHK_W'(now), CHK_W'(cur));
            end
         end else begin
            active = 1'b0;
         end
         if (i_ready || d_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ready: got i_ready=%0b d_ready=%0b expected none", i_ready, d_ready);
            end else begin
               e = exp_q.pop_front();
               check("ready_resp", CHK_W'({timeout_err, d_ready, i_rdata, d_rdata}), CHK_W'(e[RW-2:0]));
               if (!e[RW-1]) check("ready_latency", CHK_W'(cyc), CHK_W'(pulse_cyc + 1));
            end
         end
      end
   end

   task automatic exp_cmd(input bit gd, input bit rd, input bit wr,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
      cmd_q.push_back({gd, rd, wr, a, (wr ? wd : {DATA_W{1'b0}})});
   endtask

   task automatic exp_rsp(input bit is_to, input bit to_err, input bit side);
      exp_q.push_back({is_to, to_err, side, exp_i, exp_d});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, CHK_W'({mem_read, mem_write, i_ready, d_ready, grant_d, timeout_err, dbg_state}), '0);
      check({tag, "_addr"}, CHK_W'(mem_addr), '0);
      check({tag, "_wdata"}, CHK_W'(mem_wdata), '0);
      check({tag, "_rdata"}, CHK_W'({i_rdata, d_rdata}), '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst   = 1'b0;
      exp_i = '0;
      exp_d = '0;
   endtask

   // driver tasks: raise a request, hold it until ready (bounded), drop it
   task automatic i_txn(input logic [ADDR_W-1:0] a);
      int k;
      @(negedge clk);
      i_read = 1'b1;
      i_addr = a;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!i_ready && k < 200);
      if (!i_ready) check("i_ready_wait", '0, CHK_W'(1));
      i_read = 1'b0;
   endtask

   task automatic d_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd);
      int k;
      @(negedge clk);
      d_read  = rd;
      d_write = wr;
      d_addr  = a;
      d_wdata = wd;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!d_ready && k < 200);
      if (!d_ready) check("d_ready_wait", '0, CHK_W'(1));
      d_read  = 1'b0;
      d_write = 1'b0;
   endtask

   // stimulus
   initial begin
      int k, n;
      rst = 1'b1; i_read = 1'b0; i_addr = '0;
      d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
      exp_i = '0; exp_d = '0;

      // single I read
      do_reset();
      exp_cmd(1'b0, 1'b1, 1'b0, 28'h0000040, '0);
      exp_i = A5_LINE;
      exp_rsp(1'b0, 1'b0, 1'b0);
      fork
         i_txn(28'h0000040);
         begin
            @(negedge clk);
            check("cmd_not_early", CHK_W'(mem_read), '0);
            @(negedge clk);
            check("cmd_at_t1", CHK_W'({mem_read, mem_addr}), CHK_W'({1'b1, 28'h0000040}));
         end
      join

      // D write-back, then a read+write request serviced as a write
      exp_cmd(1'b1, 1'b0, 1'b1, 28'h0000100, WB_LINE);
      exp_rsp(1'b0, 1'b0, 1'b1);
      d_txn(1'b0, 1'b1, 28'h0000100, WB_LINE);
      exp_cmd(1'b1, 1'b0, 1'b1, 28'h0000180, WB_LINE2);
      exp_rsp(1'b0, 1'b0, 1'b1);
      d_txn(1'b1, 1'b1, 28'h0000180, WB_LINE2);

      // simultaneous I and D reads out of reset: I first
      do_reset();
      exp_cmd(1'b0, 1'b1, 1'b0, 28'h0000200, '0);
      exp_i = line_for(28'h0000200);
      exp_rsp(1'b0, 1'b0, 1'b0);
      exp_cmd(1'b1, 1'b1, 1'b0, 28'h0000300, '0);
      exp_d = line_for(28'h0000300);
      exp_rsp(1'b0, 1'b0, 1'b1);
      fork
         i_txn(28'h0000200);
         d_txn(1'b1, 1'b0, 28'h0000300, '0);
      join

      // continuous contention: I, D, I, D
      exp_cmd(1'b0, 1'b1, 1'b0, 28'h0000400, '0);
      exp_i = line_for(28'h0000400);
      exp_rsp(1'b0, 1'b0, 1'b0);
      exp_cmd(1'b1, 1'b1, 1'b0, 28'h0000500, '0);
      exp_d = line_for(28'h0000500);
      exp_rsp(1'b0, 1'b0, 1'b1);
      exp_cmd(1'b0, 1'b1, 1'b0, 28'h0000600, '0);
      exp_i = line_for(28'h0000600);
      exp_rsp(1'b0, 1'b0, 1'b0);
      exp_cmd(1'b1, 1'b1, 1'b0, 28'h0000700, '0);
      exp_d = line_for(28'h0000700);
      exp_rsp(1'b0, 1'b0, 1'b1);
      fork
         begin i_txn(28'h0000400); i_txn(28'h0000600); end
         begin d_txn(1'b1, 1'b0, 28'h0000500, '0); d_txn(1'b1, 1'b0, 28'h0000700, '0); end
      join

      // timeout: memory silent, command held for exactly TIMEOUT cycles
      mem_en = 1'b0;
      exp_cmd(1'b0, 1'b1, 1'b0, 28'h0000800, '0);
      exp_rsp(1'b1, 1'b1, 1'b0);
      fork
         i_txn(28'h0000800);
         begin
            k = 0;
            while (!mem_read && k < 50) begin @(negedge clk); k++; end
            n = 0;
            while (mem_read && n < 50) begin n++; @(negedge clk); end
            check("timeout_cmd_cycles", CHK_W'(n), CHK_W'(TIMEOUT));
         end
      join
      check("timeout_err_set", CHK_W'(timeout_err), CHK_W'(1));
      mem_en = 1'b1;
      exp_cmd(1'b0, 1'b1, 1'b0, 28'h0000040, '0);
      exp_i = A5_LINE;
      exp_rsp(1'b0, 1'b1, 1'b0);
      i_txn(28'h0000040);
      @(negedge clk);
      check("timeout_err_sticky", CHK_W'(timeout_err), CHK_W'(1));

      // reset during ISSUE, then a stray mem_ready
      mem_en = 1'b0;
      exp_cmd(1'b0, 1'b1, 1'b0, 28'h0000900, '0);
      @(negedge clk);
      i_read = 1'b1;
      i_addr = 28'h0000900;
      repeat (4) @(negedge clk);
      check("issue_before_rst", CHK_W'({dbg_state, mem_read}), CHK_W'({2'd1, 1'b1}));
      rst    = 1'b1;
      i_read = 1'b0;
      @(negedge clk);
      check_all_zero("mid_rst");
      rst = 1'b0;
      late_req++;
      repeat (4) @(negedge clk);
      check_all_zero("late_ready");
      mem_en = 1'b1;

      check("exp_q_drained", CHK_W'(exp_q.size()), '0);
      check("cmd_q_drained", CHK_W'(cmd_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
